serial_sub_4bit: RTL and testbench
==================================

# serial_sub_4bit

Bit-serial, multi-cycle subtractor: the inverse of the team's combinational 4-bit full adder. It computes d = a − b with borrow out, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It sits beside the adder datapath as the reverse arithmetic path. A start/busy/done handshake lets a controller launch an operation and collect the result.

## Interface
- WIDTH, 4: operand/result width in bits; legal range ≥ 2.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; **synchronous, active-high**; single clock domain.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  minuend; captured on the accepted start edge.
- b  in  WIDTH  subtrahend; captured on the accepted start edge.
- busy  out  1  high while in SHIFT or DONE.
- done  out  1  one-cycle pulse; d/bo (and ovf) are valid from this cycle.
- d  out  WIDTH  difference a − b mod 2^WIDTH.
- bo  out  1  borrow out: 1 iff unsigned a < b (the mirror of the adder's carry c).
- ovf  out  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: load shift registers sa←a, sb←b; clear the borrow FF br←0; set the bit counter cnt←0; go to SHIFT.
  - On start=0: stay in IDLE.
- SHIFT, each cycle:
  - Difference bit: x = sa[0] ^ sb[0] ^ br.
  - Next borrow: br ← (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - Result register: sr ← {x, sr[WIDTH-1:1]}.
  - Operands: sa and sb shift right by one.
  - cnt increments. When cnt == WIDTH−1, go to DONE.
- DONE, one cycle:
  - d ← final sr and bo ← final br, both loaded on DONE entry.
  - done=1.
  - Return to IDLE.
- d and bo hold their values until the next operation's DONE entry. They do not change during a later SHIFT.
- start while busy=1, including the DONE cycle, is ignored. It is not queued.
- a and b may change freely after the start edge; the block uses only the captured copies.
- Arithmetic: pure modulo 2^WIDTH.
  - 0 − 1 gives all-ones with bo=1.
  - x − x gives 0 with bo=0.
- Reset values: busy=0, done=0, d=0, bo=0, ovf=0; state=IDLE; cnt=0; br=0.
- rst mid-operation (SHIFT or DONE): abort on that edge and apply all reset values. The aborted operation never produces a done pulse.
- rst has priority over start in the same cycle.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycles 1..WIDTH: SHIFT with busy=1. For WIDTH=4 this is cycles 1–4.
- Cycle WIDTH+1: DONE with done=1, busy=1, result valid.
- Cycle WIDTH+2: IDLE with busy=0. The next start is accepted on this edge.
- Latency from start to done: WIDTH+1 clocks.
- Throughput: one operation per WIDTH+2 clocks.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - Port ovf exists.
  - In DONE, ovf ← (a_cap[MSB] ≠ b_cap[MSB]) & (d[MSB] ≠ a_cap[MSB]), computed on the captured operands.
  - ovf holds with d and resets to 0.
- SERIAL_SUB_OVF_EN undefined:
  - Port ovf and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Basic difference: rst 2 cycles, then start with a=12, b=8 → done exactly 5 clocks after start; d=4, bo=0; busy high for cycles 1–5.
- Negative result and ignored start: a=4, b=10 → d=10 (0xA), bo=1. Pulse start again at cycle 2 with a=1, b=1 → ignored; the result stays 0xA.
- Zero and equality cases:
  - a=15, b=15 → d=0, bo=0.
  - Back-to-back: a=0, b=1 with start in the first IDLE cycle → d=15, bo=1, done 5 clocks later.
- Abort on reset: rst asserted at cycle 3 of a=9, b=2 → next cycle busy=0, d=0, bo=0, and no done pulse. A fresh start with a=9, b=2 → d=7, bo=0.
- Overflow, with SERIAL_SUB_OVF_EN only:
  - a=8, b=1 → d=7, bo=0, ovf=1.
  - a=3, b=5 → d=14, bo=1, ovf=0.
- Exhaustive sweep: all 256 (a,b) pairs, each checked against (a − b) mod 16 and bo = (a < b). Also confirm that d is stable between done pulses.

Source files
------------

// File: rtl/serial_sub_4bit.sv
// serial_sub_4bit: bit-serial a - b with borrow out, LSB first, one bit
// per clock through a single full-subtractor cell and a borrow flop.
// Ports: clk, rst (sync, active-high), start, a, b -> busy, done, d, bo
// Optional: ovf (signed overflow) when SERIAL_SUB_OVF_EN is defined.
module serial_sub_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
  output logic             bo,
  output logic             ovf
`else
  output logic             bo
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic             w_x;
  logic             w_br_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_sa_nxt;

  // Full-subtractor cell
  assign w_x      = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_nxt = (~r_sa[0] & r_sb[0]) |
                    (~(r_sa[0] ^ r_sb[0]) & r_br);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Difference bits enter the minuend register from the top as its
  // bits leave from the bottom; after WIDTH shifts it holds the result.
  assign w_sa_nxt = {w_x, r_sa[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic w_ovf;

  // Signs differ and the result sign departs from the minuend's sign.
  assign w_ovf = (r_a_msb ^ r_b_msb) & (w_x ^ r_a_msb);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      d       <= '0;
      bo      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
`endif
          end
        end
        S_SHIFT: begin
          r_sa  <= w_sa_nxt;
          r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
          r_br  <= w_br_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // Result and borrow land on the outputs as DONE is entered.
            d       <= w_sa_nxt;
            bo      <= w_br_nxt;
            done    <= 1'b1;
            r_state <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= w_ovf;
`endif
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_cnt   <= '0;
          r_br    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_4bit.sv
// tb_serial_sub_4bit: directed and exhaustive checks of serial_sub_4bit
// against a cycle-level arithmetic model of the handshake and result.
module tb_serial_sub_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  serial_sub_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
`ifdef SERIAL_SUB_OVF_EN
    .bo    (bo),
    .ovf   (ovf)
`else
    .bo    (bo)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Model: remaining busy cycles, and the outputs the DONE cycle exposes.
  int           m_left = 0;
  logic [W-1:0] m_d = '0;
  logic         m_bo = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_d;
  logic         p_bo;
  logic         p_ovf;

  function automatic int sval(input logic [W-1:0] v);
    int r;
    r = int'(v);
    if (r >= (1 << (W - 1))) r = r - (1 << W);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_d    = '0;
      m_bo   = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        int diff;
        m_left = W + 1;
        p_d    = W'((int'(a) - int'(b) + (1 << W)) % (1 << W));
        p_bo   = (int'(a) < int'(b));
        diff   = sval(a) - sval(b);
        p_ovf  = (diff < -(1 << (W - 1))) || (diff > (1 << (W - 1)) - 1);
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        m_d   = p_d;
        m_bo  = p_bo;
        m_ovf = p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 32'(busy), 32'(m_left > 0));
      chk("cyc_done", 32'(done), 32'(m_left == 1));
      chk("cyc_d", 32'(d), 32'(m_d));
      chk("cyc_bo", 32'(bo), 32'(m_bo));
`ifdef SERIAL_SUB_OVF_EN
      chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  // Launch one op, scramble the inputs, wait (bounded) for done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb);
    int n;
    @(negedge clk);
    a = ta;
    b = tb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(W + 1));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bo", 32'(bo), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;

    run_op(4'd12, 4'd8);
    chk("b12m8_d", 32'(d), 32'd4);
    chk("b12m8_bo", 32'(bo), 32'd0);

    // Negative result with a start pulse during SHIFT that must be dropped
    @(negedge clk);
    a = 4'd4;
    b = 4'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1;
    b = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int n;
      n = 3;
      while (done !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("ign_latency", 32'(n), 32'(W + 1));
    end
    chk("ign_d", 32'(d), 32'd10);
    chk("ign_bo", 32'(bo), 32'd1);

    run_op(4'd15, 4'd15);
    chk("eq_d", 32'(d), 32'd0);
    chk("eq_bo", 32'(bo), 32'd0);
    run_op(4'd0, 4'd1);
    chk("b2b_d", 32'(d), 32'd15);
    chk("b2b_bo", 32'(bo), 32'd1);

    // Abort mid-operation with reset
    @(negedge clk);
    a = 4'd9;
    b = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_d", 32'(d), 32'd0);
    chk("abort_bo", 32'(bo), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_nodone", 32'(done), 32'd0);
    end
    run_op(4'd9, 4'd2);
    chk("fresh_d", 32'(d), 32'd7);
    chk("fresh_bo", 32'(bo), 32'd0);

    run_op(4'd8, 4'd1);
    chk("o81_d", 32'(d), 32'd7);
    chk("o81_bo", 32'(bo), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("o81_ovf", 32'(ovf), 32'd1);
`endif
    run_op(4'd3, 4'd5);
    chk("o35_d", 32'(d), 32'd14);
    chk("o35_bo", 32'(bo), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
    chk("o35_ovf", 32'(ovf), 32'd0);
`endif

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(W'(i), W'(j));
        chk("sweep_d", 32'(d), 32'((i - j + 16) % 16));
        chk("sweep_bo", 32'(bo), 32'(i < j));
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
